pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and redirect controller for the five-stage MIPS pipeline.
- Replaces the fixed two-source forwarding and single-cycle load-use logic with a scoreboard of in-flight writers.
- The scoreboard covers EX, a configurable number of MEM stages and WB.
- Drives the ID stall, the IF/ID/EX flushes, registered PC redirects and the operand-forwarding selects for EX.

---
 rtl/pipe_hazard_pkg.sv | 37 +++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_e  : EX operand source select (regfile / MEM1 ALU result / WB data)
//   slot_t     : one in-flight writer tracked by the scoreboard
//   slot_match : does a slot produce a given source register?
//   fwd_pick   : forwarding select for one EX source
package pipe_hazard_pkg;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned RIDX_DEF = $clog2(NREG_DEF);

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                vld;
        logic                wr_en;
        logic [RIDX_DEF-1:0] wr_reg;
        logic                is_load;
    } slot_t;

    // Register 0 is hardwired to zero, so it never produces a dependency.
    function automatic logic slot_match(slot_t s, logic [RIDX_DEF-1:0] src, logic use_src);
        return s.vld && s.wr_en && (s.wr_reg == src) && (src != '0) && use_src;
    endfunction

    // MEM1 is younger than WB, so it is tested first; a load in MEM1 has no data yet.
    function automatic fwd_sel_e fwd_pick(slot_t s_mem, slot_t s_wb,
                                          logic [RIDX_DEF-1:0] src, logic use_src);
        if (slot_match(s_mem, src, use_src) && !s_mem.is_load) return FWD_MEM;
        if (slot_match(s_wb, src, use_src))                    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : count one event this cycle
//   o_cnt      : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard, forwarding and redirect control for the 5-stage pipe.
//   clk, reset          : clock, asynchronous active-low reset
//   id_*                : instruction currently in ID (sources, destination, load flag)
//   redir_req/addr      : taken branch/jump resolved in MEM1
//   stall               : hold PC and IF/ID, bubble into EX
//   flush_if/id/ex      : squash pipeline registers on redirect
//   fwd_a/fwd_b         : EX operand selects (0 regfile, 1 MEM1, 2 WB)
//   pc_redir_vld/addr   : registered one-cycle redirect to the PC
//   stall_cnt/flush_cnt : saturating performance counters
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned RIDX     = $clog2(NREG),
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RIDX-1:0]  id_rs,
    input  logic [RIDX-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [RIDX-1:0]  id_wr_reg,
    input  logic             id_is_load,
    input  logic             redir_req,
    input  logic [XLEN-1:0]  redir_addr,
    output logic             stall,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_redir_vld,
    output logic [XLEN-1:0]  pc_redir_addr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // S0 = EX, S1..S_LAT = MEM, S_LAT+1 = WB
    localparam int unsigned NSLOT = LOAD_LAT + 2;
    localparam int unsigned WB    = LOAD_LAT + 1;

    slot_t               r_slot [NSLOT];
    logic [RIDX_DEF-1:0] r_rs;
    logic [RIDX_DEF-1:0] r_rt;
    logic                r_use_rs;
    logic                r_use_rt;
    logic                r_redir_vld;
    logic [XLEN-1:0]     r_redir_addr;

    logic [RIDX_DEF-1:0] w_id_rs;
    logic [RIDX_DEF-1:0] w_id_rt;
    logic                w_hazard;
    logic                w_s0_load;

    assign w_id_rs = RIDX_DEF'(id_rs);
    assign w_id_rt = RIDX_DEF'(id_rt);

    // A consumer released now reaches EX when the producer sits one slot older;
    // only MEM1 (non-load) and WB can forward, so everything in between must stall.
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned k = 0; k < LOAD_LAT; k++) begin
            if (r_slot[k].is_load || (k != 0)) begin
                if (slot_match(r_slot[k], w_id_rs, id_use_rs) ||
                    slot_match(r_slot[k], w_id_rt, id_use_rt)) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    // Redirect wins over stall; reset gating keeps the outputs low while reset is held.
    assign stall     = w_hazard && id_valid && !redir_req && reset;
    assign flush_if  = redir_req && reset;
    assign flush_id  = redir_req && reset;
    assign flush_ex  = redir_req && reset;
    assign w_s0_load = id_valid && !stall && !redir_req;

    assign fwd_a = 2'(fwd_pick(r_slot[1], r_slot[WB], r_rs, r_use_rs));
    assign fwd_b = 2'(fwd_pick(r_slot[1], r_slot[WB], r_rt, r_use_rt));

    assign pc_redir_vld  = r_redir_vld;
    assign pc_redir_addr = r_redir_addr;

    // Scoreboard shift plus registered redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                r_slot[k] <= '0;
            end
            r_rs         <= '0;
            r_rt         <= '0;
            r_use_rs     <= 1'b0;
            r_use_rt     <= 1'b0;
            r_redir_vld  <= 1'b0;
            r_redir_addr <= '0;
        end else begin
            for (int unsigned k = 1; k < NSLOT; k++) begin
                r_slot[k] <= r_slot[k-1];
            end
            if (w_s0_load) begin
                r_slot[0] <= '{vld: 1'b1, wr_en: id_wr_en,
                               wr_reg: RIDX_DEF'(id_wr_reg), is_load: id_is_load};
                r_rs      <= w_id_rs;
                r_rt      <= w_id_rt;
                r_use_rs  <= id_use_rs;
                r_use_rt  <= id_use_rt;
            end else begin
                r_slot[0] <= '0;
                r_use_rs  <= 1'b0;
                r_use_rt  <= 1'b0;
            end
            r_redir_vld <= redir_req;
            if (redir_req) begin
                r_redir_addr <= redir_addr;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_inc (stall),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_inc (flush_if),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: u1 has one MEM stage, u3 three, u4 three with 4-bit counters.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, redir_req;
    logic [4:0]  id_rs, id_rt, id_wr_reg;
    logic [31:0] redir_addr;

    logic        a1_stall, a1_fif, a1_fid, a1_fex, a1_pv;
    logic [1:0]  a1_fa, a1_fb;
    logic [31:0] a1_pa;
    logic [15:0] a1_sc, a1_fc;
    logic        a3_stall, a3_fif, a3_fid, a3_fex, a3_pv;
    logic [1:0]  a3_fa, a3_fb;
    logic [31:0] a3_pa;
    logic [15:0] a3_sc, a3_fc;
    logic        a4_stall, a4_fif, a4_fid, a4_fex, a4_pv;
    logic [1:0]  a4_fa, a4_fb;
    logic [31:0] a4_pa;
    logic [3:0]  a4_sc, a4_fc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .redir_req(redir_req),
        .redir_addr(redir_addr), .stall(a1_stall), .flush_if(a1_fif), .flush_id(a1_fid),
        .flush_ex(a1_fex), .fwd_a(a1_fa), .fwd_b(a1_fb), .pc_redir_vld(a1_pv),
        .pc_redir_addr(a1_pa), .stall_cnt(a1_sc), .flush_cnt(a1_fc));

    pipe_hazard_ctrl #(.LOAD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .redir_req(redir_req),
        .redir_addr(redir_addr), .stall(a3_stall), .flush_if(a3_fif), .flush_id(a3_fid),
        .flush_ex(a3_fex), .fwd_a(a3_fa), .fwd_b(a3_fb), .pc_redir_vld(a3_pv),
        .pc_redir_addr(a3_pa), .stall_cnt(a3_sc), .flush_cnt(a3_fc));

    pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) u4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .redir_req(redir_req),
        .redir_addr(redir_addr), .stall(a4_stall), .flush_if(a4_fif), .flush_id(a4_fid),
        .flush_ex(a4_fex), .fwd_a(a4_fa), .fwd_b(a4_fb), .pc_redir_vld(a4_pv),
        .pc_redir_addr(a4_pa), .stall_cnt(a4_sc), .flush_cnt(a4_fc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = '0; id_is_load = 1'b0; redir_req = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic wen, input logic [4:0] wreg,
                         input logic ld);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = wen; id_wr_reg = wreg; id_is_load = ld;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle();
        redir_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        checks++; if ({a1_stall, a1_fif, a1_fid, a1_fex, a1_pv} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got=%b exp=00000", {a1_stall, a1_fif, a1_fid, a1_fex, a1_pv}); end
        checks++; if ({a1_fa, a1_fb, a3_fa, a3_fb} !== 8'h00) begin
            errors++; $display("FAIL reset_fwd got=%h exp=00", {a1_fa, a1_fb, a3_fa, a3_fb}); end
        checks++; if ({a1_pa, a1_sc, a1_fc} !== 64'h0) begin
            errors++; $display("FAIL reset_regs got=%h exp=0", {a1_pa, a1_sc, a1_fc}); end
        tick();
    endtask

    // lw r1 ; add r2,r1,r3 with one MEM stage
    task automatic test_load_use_lat1();
        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1); #2;
        checks++; if (a1_stall !== 1'b0) begin errors++; $display("FAIL lu1_lw_in_id got=%b exp=0", a1_stall); end
        tick();
        issue(5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0); #2;
        checks++; if (a1_stall !== 1'b1) begin errors++; $display("FAIL lu1_stall got=%b exp=1", a1_stall); end
        tick(); #2;
        checks++; if (a1_stall !== 1'b0) begin errors++; $display("FAIL lu1_release got=%b exp=0", a1_stall); end
        tick(); idle(); #2;
        checks++; if ({a1_fa, a1_fb} !== {2'd2, 2'd0}) begin
            errors++; $display("FAIL lu1_fwd got=%0d/%0d exp=2/0", a1_fa, a1_fb); end
        checks++; if (a1_sc !== 16'd1) begin errors++; $display("FAIL lu1_stall_cnt got=%0d exp=1", a1_sc); end
        tick();
    endtask

    // add r1 ; sub r4,r1,r1 ; and r7,r1,r1 with one MEM stage
    task automatic test_alu_fwd_lat1();
        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
        tick();
        issue(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); #2;
        checks++; if (a1_stall !== 1'b0) begin errors++; $display("FAIL alu1_nostall got=%b exp=0", a1_stall); end
        tick();
        issue(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0); #2;
        checks++; if ({a1_fa, a1_fb} !== {2'd1, 2'd1}) begin
            errors++; $display("FAIL alu1_fwd_mem got=%0d/%0d exp=1/1", a1_fa, a1_fb); end
        tick(); idle(); #2;
        checks++; if ({a1_fa, a1_fb} !== {2'd2, 2'd2}) begin
            errors++; $display("FAIL alu1_fwd_wb got=%0d/%0d exp=2/2", a1_fa, a1_fb); end
        tick();
    endtask

    // Three MEM stages: load-use, adjacent ALU use, ALU use after a bubble
    task automatic test_lat3();
        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
        tick();
        issue(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (a3_stall !== 1'b1) begin errors++; $display("FAIL lat3_lw_stall c=%0d got=%b exp=1", c, a3_stall); end
            tick();
        end
        #2;
        checks++; if (a3_stall !== 1'b0) begin errors++; $display("FAIL lat3_lw_release got=%b exp=0", a3_stall); end
        tick(); idle(); #2;
        checks++; if ({a3_fa, a3_fb} !== {2'd2, 2'd0}) begin
            errors++; $display("FAIL lat3_lw_fwd got=%0d/%0d exp=2/0", a3_fa, a3_fb); end
        checks++; if (a3_sc !== 16'd3) begin errors++; $display("FAIL lat3_lw_cnt got=%0d exp=3", a3_sc); end
        tick();

        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        issue(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); #2;
        checks++; if (a3_stall !== 1'b0) begin errors++; $display("FAIL lat3_add_adj_stall got=%b exp=0", a3_stall); end
        tick(); idle(); #2;
        checks++; if (a3_fa !== 2'd1) begin errors++; $display("FAIL lat3_add_adj_fwd got=%0d exp=1", a3_fa); end
        tick();

        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick(); idle();
        tick();
        issue(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (a3_stall !== 1'b1) begin errors++; $display("FAIL lat3_add_gap_stall c=%0d got=%b exp=1", c, a3_stall); end
            tick();
        end
        #2;
        checks++; if (a3_stall !== 1'b0) begin errors++; $display("FAIL lat3_add_gap_release got=%b exp=0", a3_stall); end
        tick(); idle(); #2;
        checks++; if (a3_fa !== 2'd2) begin errors++; $display("FAIL lat3_add_gap_fwd got=%0d exp=2", a3_fa); end
        checks++; if (a3_sc !== 16'd2) begin errors++; $display("FAIL lat3_add_gap_cnt got=%0d exp=2", a3_sc); end
        tick();
    endtask

    // r0 destination and unused sources never create hazards
    task automatic test_r0_and_unused();
        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
        tick();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0); #2;
        checks++; if (a1_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=0", a1_stall); end
        tick(); idle(); #2;
        checks++; if ({a1_fa, a1_fb} !== 4'h0) begin errors++; $display("FAIL r0_fwd got=%0d/%0d exp=0/0", a1_fa, a1_fb); end
        tick();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        tick();
        issue(5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0); #2;
        checks++; if (a1_stall !== 1'b0) begin errors++; $display("FAIL unused_stall got=%b exp=0", a1_stall); end
        tick(); idle(); #2;
        checks++; if ({a1_fa, a1_fb} !== 4'h0) begin errors++; $display("FAIL unused_fwd got=%0d/%0d exp=0/0", a1_fa, a1_fb); end
        tick();
    endtask

    // Redirect overriding a load-use stall, then back-to-back redirects
    task automatic test_redirect();
        apply_reset();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1);
        tick();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        redir_req = 1'b1; redir_addr = 32'h40; #2;
        checks++; if (a1_stall !== 1'b0) begin errors++; $display("FAIL redir_stall got=%b exp=0", a1_stall); end
        checks++; if ({a1_fif, a1_fid, a1_fex} !== 3'b111) begin
            errors++; $display("FAIL redir_flush got=%b exp=111", {a1_fif, a1_fid, a1_fex}); end
        checks++; if (a1_pv !== 1'b0) begin errors++; $display("FAIL redir_early_vld got=%b exp=0", a1_pv); end
        tick();
        issue(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        redir_req = 1'b0; #2;
        checks++; if ({a1_pv, a1_pa} !== {1'b1, 32'h40}) begin
            errors++; $display("FAIL redir_pulse got=%b/%h exp=1/00000040", a1_pv, a1_pa); end
        checks++; if ({a1_fif, a1_fc, a1_sc} !== {1'b0, 16'd1, 16'd0}) begin
            errors++; $display("FAIL redir_cnts got=%b/%0d/%0d exp=0/1/0", a1_fif, a1_fc, a1_sc); end
        tick(); idle(); #2;
        checks++; if ({a1_pv, a1_fa} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL redir_s0_bubble got=%b/%0d exp=0/0", a1_pv, a1_fa); end
        tick();
        redir_req = 1'b1; redir_addr = 32'h80; #2;
        checks++; if (a1_fex !== 1'b1) begin errors++; $display("FAIL b2b_flush got=%b exp=1", a1_fex); end
        tick();
        redir_addr = 32'hC4; #2;
        checks++; if ({a1_pv, a1_pa} !== {1'b1, 32'h80}) begin
            errors++; $display("FAIL b2b_first got=%b/%h exp=1/00000080", a1_pv, a1_pa); end
        tick(); idle(); #2;
        checks++; if ({a1_pv, a1_pa, a1_fc} !== {1'b1, 32'hC4, 16'd3}) begin
            errors++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/000000c4/3", a1_pv, a1_pa, a1_fc); end
        tick(); #2;
        checks++; if (a1_pv !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", a1_pv); end
        tick();
    endtask

    // Counter saturation, then asynchronous reset in the middle of a stall
    task automatic test_saturate_and_reset();
        apply_reset();
        redir_req = 1'b1; redir_addr = 32'h1234;
        repeat (65540) tick();
        idle();
        tick();
        for (int r = 0; r < 6; r++) begin
            issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
            tick();
            issue(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
            repeat (4) tick();
        end
        idle(); #2;
        checks++; if ({a3_fc, a4_fc} !== {16'hFFFF, 4'hF}) begin
            errors++; $display("FAIL sat_flush got=%h/%h exp=ffff/f", a3_fc, a4_fc); end
        checks++; if ({a3_sc, a4_sc} !== {16'd18, 4'hF}) begin
            errors++; $display("FAIL sat_stall got=%0d/%0d exp=18/15", a3_sc, a4_sc); end
        tick();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
        tick();
        issue(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); #2;
        checks++; if (a3_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%b exp=1", a3_stall); end
        reset = 1'b0; redir_req = 1'b1; #1;
        checks++; if ({a3_stall, a3_fif, a3_fid, a3_fex, a3_pv, a3_fa, a3_fb} !== 9'b0) begin
            errors++; $display("FAIL rst_async_ctl got=%b exp=0", {a3_stall, a3_fif, a3_fid, a3_fex, a3_pv, a3_fa, a3_fb}); end
        checks++; if ({a3_pa, a3_sc, a3_fc, a4_sc, a4_fc} !== 72'h0) begin
            errors++; $display("FAIL rst_async_regs got=%h exp=0", {a3_pa, a3_sc, a3_fc, a4_sc, a4_fc}); end
        redir_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #2;
        checks++; if (a3_stall !== 1'b0) begin errors++; $display("FAIL rst_post_empty got=%b exp=0", a3_stall); end
        tick(); #2;
        checks++; if ({a3_stall, a3_fa} !== 3'b0) begin
            errors++; $display("FAIL rst_post_fwd got=%b/%0d exp=0/0", a3_stall, a3_fa); end
        tick();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
        tick();
        issue(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); #2;
        checks++; if (a3_stall !== 1'b1) begin errors++; $display("FAIL rst_new_hazard got=%b exp=1", a3_stall); end
        tick(); idle();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        redir_addr = '0;
        test_reset();
        test_load_use_lat1();
        test_alu_fwd_lat1();
        test_lat3();
        test_r0_and_unused();
        test_redirect();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
